// File: rtl/soc_multi_timer.sv
// -----------------------------------------------------------------------------
// soc_multi_timer
//
// Multi-channel interval timer on a 32-bit Avalon-MM slave port. Each of the
// NUM_CH channels has an 8-bit prescaler and a CNT_W-bit down-counter. A channel
// runs in one-shot or continuous mode and can drive a compare-based PWM output.
// Sticky timeout flags are combined with per-channel enables into one interrupt.
// A command register starts or stops any set of channels in one write.
//
// Register map (word addresses):
//   0 STATUS : [NUM_CH-1:0] timeout flags (write 1 to clear),
//              [8+NUM_CH-1:8] run flags (read-only)
//   1 IRQ_EN : [NUM_CH-1:0] interrupt enables
//   2 CMD    : bit c starts channel c, bit 8+c stops it (reads 0)
//   3        : reserved
//   4*(c+1)+0 CTRL    : [0] CONT, [1] PWM_EN, [15:8] PRESC
//   4*(c+1)+1 PERIOD
//   4*(c+1)+2 COMPARE
//   4*(c+1)+3 COUNT   : live count (read-only)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data for the presented address
//   irq        registered OR of (timeout flag & irq enable)
//   pwm_out    registered per-channel PWM outputs
// -----------------------------------------------------------------------------
module soc_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 9999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

  logic              wr;
  logic              wr_status;
  logic              wr_irq_en;
  logic              wr_cmd;
  logic [2:0]        ch_sel;

  logic [NUM_CH-1:0] flag;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] cont;
  logic [NUM_CH-1:0] pwm_en;
  logic [7:0]        presc   [NUM_CH];
  logic [7:0]        psc     [NUM_CH];
  logic [CNT_W-1:0]  period  [NUM_CH];
  logic [CNT_W-1:0]  compare [NUM_CH];
  logic [CNT_W-1:0]  count   [NUM_CH];

  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] timeout;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] wr_compare;
  logic [31:0]       rd_mux;

  assign wr        = chipselect & ~write_n;
  assign ch_sel    = address[4:2];
  assign wr_status = wr & (address == 5'd0);
  assign wr_irq_en = wr & (address == 5'd1);
  assign wr_cmd    = wr & (address == 5'd2);

  // Per-channel command decode and tick/timeout detection. A start or stop in
  // the same cycle as a tick takes precedence over the tick entirely.
  always_comb begin
    start      = '0;
    stop       = '0;
    tick       = '0;
    timeout    = '0;
    wr_ctrl    = '0;
    wr_period  = '0;
    wr_compare = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      stop[c]       = wr_cmd & writedata[8+c];
      start[c]      = wr_cmd & writedata[c] & ~writedata[8+c];
      tick[c]       = run[c] & (psc[c] == 8'd0);
      timeout[c]    = tick[c] & ~start[c] & ~stop[c] & (count[c] == '0);
      wr_ctrl[c]    = wr & (ch_sel == 3'(c + 1)) & (address[1:0] == 2'd0);
      wr_period[c]  = wr & (ch_sel == 3'(c + 1)) & (address[1:0] == 2'd1);
      wr_compare[c] = wr & (ch_sel == 3'(c + 1)) & (address[1:0] == 2'd2);
    end
  end

  // Read multiplexer; everything not explicitly mapped reads as zero.
  always_comb begin
    rd_mux = '0;
    if (address == 5'd0) begin
      rd_mux[NUM_CH-1:0] = flag;
      rd_mux[8 +: NUM_CH] = run;
    end else if (address == 5'd1) begin
      rd_mux[NUM_CH-1:0] = irq_en;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 3'(c + 1)) begin
          case (address[1:0])
            2'd0:    rd_mux[15:0]      = {presc[c], 6'd0, pwm_en[c], cont[c]};
            2'd1:    rd_mux[CNT_W-1:0] = period[c];
            2'd2:    rd_mux[CNT_W-1:0] = compare[c];
            default: rd_mux[CNT_W-1:0] = count[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      pwm_out  <= '0;
      flag     <= '0;
      run      <= '0;
      irq_en   <= '0;
      cont     <= '0;
      pwm_en   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        presc[c]   <= '0;
        psc[c]     <= '0;
        period[c]  <= RST_CNT;
        compare[c] <= '0;
        count[c]   <= RST_CNT;
      end
    end else begin
      readdata <= rd_mux;
      irq      <= |(flag & irq_en);
      if (wr_irq_en) irq_en <= writedata[NUM_CH-1:0];

      for (int c = 0; c < NUM_CH; c++) begin
        pwm_out[c] <= pwm_en[c] & run[c] & (count[c] < compare[c]);

        if (wr_ctrl[c]) begin
          cont[c]   <= writedata[0];
          pwm_en[c] <= writedata[1];
          presc[c]  <= writedata[15:8];
        end
        if (wr_compare[c]) compare[c] <= writedata[CNT_W-1:0];
        if (wr_period[c])  period[c]  <= writedata[CNT_W-1:0];

        if (stop[c]) begin
          run[c] <= 1'b0;
        end else if (start[c]) begin
          run[c]   <= 1'b1;
          count[c] <= period[c];
          psc[c]   <= presc[c];
        end else if (run[c]) begin
          if (tick[c]) begin
            psc[c] <= presc[c];
            if (timeout[c]) begin
              count[c] <= period[c];
              run[c]   <= cont[c];
            end else begin
              count[c] <= count[c] - CNT_W'(1);
            end
          end else begin
            psc[c] <= psc[c] - 8'd1;
          end
        end

        // A stopped channel follows PERIOD writes immediately; a running one
        // only picks the new value up at its next reload.
        if (wr_period[c] && !run[c]) count[c] <= writedata[CNT_W-1:0];

        // Set has priority over a simultaneous write-1-to-clear.
        flag[c] <= (flag[c] & ~(wr_status & writedata[c])) | timeout[c];
      end
    end
  end

endmodule

// File: tb/tb_soc_multi_timer.sv
module tb_soc_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  addr;
  logic        cs;
  logic        wn;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  pwm_out;

  int tests = 0;
  int fails = 0;
  int hi;

  always #5 clk = ~clk;

  soc_multi_timer #(.NUM_CH(2), .CNT_W(32), .RESET_PERIOD(9999)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (addr),
    .chipselect (cs),
    .write_n    (wn),
    .writedata  (wdata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  // Reference model: channel state kept as plain numbers.
  logic [31:0] m_per [2];
  logic [31:0] m_cmp [2];
  logic [31:0] m_cnt [2];
  int          m_presc [2];
  int          m_wait [2];   // cycles still to wait before the next tick
  bit          m_cont [2];
  bit          m_pwm [2];
  bit          m_run [2];
  bit          m_flag [2];
  bit          m_ien [2];
  logic [31:0] m_rd;
  logic        m_irq;
  logic [1:0]  m_pwmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_per[i] = 32'd9999; m_cnt[i] = 32'd9999; m_cmp[i] = 0;
      m_presc[i] = 0; m_wait[i] = 0;
      m_cont[i] = 0; m_pwm[i] = 0; m_run[i] = 0; m_flag[i] = 0; m_ien[i] = 0;
    end
    m_rd = 0; m_irq = 0; m_pwmo = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    int ch, off;
    v = 0;
    ch = int'(a) / 4 - 1;
    off = int'(a) % 4;
    if (a == 0) begin
      for (int i = 0; i < 2; i++) begin v[i] = m_flag[i]; v[8+i] = m_run[i]; end
    end else if (a == 1) begin
      for (int i = 0; i < 2; i++) v[i] = m_ien[i];
    end else if (a >= 4 && ch < 2) begin
      case (off)
        0: v = (32'(m_presc[ch]) << 8) | (32'(m_pwm[ch]) << 1) | 32'(m_cont[ch]);
        1: v = m_per[ch];
        2: v = m_cmp[ch];
        default: v = m_cnt[ch];
      endcase
    end
    return v;
  endfunction

  // One clock cycle: advance the model with the current bus inputs, then clock
  // the DUT and compare all registered outputs.
  task automatic cyc();
    logic [31:0] nrd;
    logic        nirq;
    logic [1:0]  npwm;
    bit          wr;
    bit          tmo [2];
    bit          was_run [2];
    wr   = cs && !wn;
    nrd  = m_read(addr);
    nirq = 0;
    for (int i = 0; i < 2; i++) begin
      nirq    = nirq | (m_flag[i] & m_ien[i]);
      npwm[i] = m_pwm[i] && m_run[i] && (m_cnt[i] < m_cmp[i]);
    end
    for (int i = 0; i < 2; i++) begin
      bit go, halt;
      was_run[i] = m_run[i];
      tmo[i] = 0;
      halt = wr && addr == 2 && wdata[8+i];
      go   = wr && addr == 2 && wdata[i];
      if (halt) begin
        m_run[i] = 0;
      end else if (go) begin
        m_run[i] = 1; m_cnt[i] = m_per[i]; m_wait[i] = m_presc[i];
      end else if (m_run[i]) begin
        if (m_wait[i] > 0) begin
          m_wait[i] = m_wait[i] - 1;
        end else begin
          m_wait[i] = m_presc[i];
          if (m_cnt[i] == 0) begin
            tmo[i] = 1; m_cnt[i] = m_per[i]; m_run[i] = m_cont[i];
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    if (wr) begin
      if (addr == 0) for (int i = 0; i < 2; i++) if (wdata[i]) m_flag[i] = 0;
      if (addr == 1) for (int i = 0; i < 2; i++) m_ien[i] = wdata[i];
      for (int i = 0; i < 2; i++) begin
        if (addr == 4*(i+1)) begin
          m_cont[i] = wdata[0]; m_pwm[i] = wdata[1]; m_presc[i] = int'(wdata[15:8]);
        end
        if (addr == 4*(i+1)+1) begin
          m_per[i] = wdata;
          if (!was_run[i]) m_cnt[i] = wdata;
        end
        if (addr == 4*(i+1)+2) m_cmp[i] = wdata;
      end
    end
    for (int i = 0; i < 2; i++) if (tmo[i]) m_flag[i] = 1;
    @(posedge clk);
    #1;
    m_rd = nrd; m_irq = nirq; m_pwmo = npwm;
    chk("readdata", readdata, m_rd);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("pwm_out", {30'd0, pwm_out}, {30'd0, m_pwmo});
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1; wn = 0; addr = a; wdata = d;
    cyc();
    cs = 0; wn = 1;
  endtask

  function automatic logic [31:0] rand_data(input logic [4:0] a);
    logic [31:0] d;
    case (a)
      5'd2:           d = $urandom & 32'h0000_0303;
      5'd4, 5'd8:     d = ($urandom & 32'hFFFF_00FC) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
      5'd5, 5'd6,
      5'd9, 5'd10:    d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 12);
      default:        d = $urandom;
    endcase
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] wa [16];
    logic [4:0] a;
    wa = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
           5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd31};
    reset_n = 0; cs = 0; wn = 1; addr = 0; wdata = 0;
    model_reset();

    // Reset state
    #3;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pwm", {30'd0, pwm_out}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    addr = 7; cyc(); chk("rst_count0", readdata, 32'd9999);
    addr = 5; cyc(); chk("rst_period0", readdata, 32'd9999);
    addr = 0; cyc(); chk("rst_status", readdata, 32'd0);

    // Continuous channel 0, PERIOD=3, interrupt enabled
    bus_write(5, 3); bus_write(4, 1); bus_write(1, 1);
    bus_write(2, 1);
    addr = 0;
    repeat (4) cyc();
    chk("irq_before_timeout", {31'd0, irq}, 32'd0);
    chk("status_running", readdata, 32'h100);
    cyc();
    chk("irq_first", {31'd0, irq}, 32'd1);
    chk("status_flag", readdata, 32'h101);
    bus_write(0, 1);
    cyc();
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    cyc(); cyc();
    chk("irq_second", {31'd0, irq}, 32'd1);
    cyc(); cyc();
    bus_write(0, 1);              // lands on a timeout edge
    cyc();
    chk("set_wins", readdata, 32'h101);
    bus_write(2, 32'h100);
    bus_write(0, 3);

    // One-shot channel 1, PERIOD=2, PRESC=4
    bus_write(9, 2); bus_write(8, 32'h400);
    bus_write(2, 2);
    addr = 0;
    repeat (14) cyc();
    cyc();
    chk("oneshot_running", readdata, 32'h200);
    cyc();
    chk("oneshot_done", readdata, 32'h002);
    addr = 11; cyc();
    chk("oneshot_count", readdata, 32'd2);
    repeat (5) cyc();
    chk("oneshot_frozen", readdata, 32'd2);
    bus_write(0, 3);

    // Lockstep start, then start+stop on channel 0
    bus_write(4, 1); bus_write(8, 1); bus_write(5, 5); bus_write(9, 5);
    bus_write(2, 3);
    addr = 7; repeat (3) cyc();
    chk("lockstep_c0", readdata, 32'd3);
    addr = 11; cyc();
    chk("lockstep_c1", readdata, 32'd2);
    bus_write(2, 32'h101);
    addr = 0; cyc();
    chk("stop_wins", readdata, 32'h200);
    addr = 7; cyc();
    chk("stopped_count", readdata, 32'd1);
    repeat (3) cyc();
    chk("stopped_frozen", readdata, 32'd1);
    bus_write(2, 32'h200);
    bus_write(0, 3);

    // PWM on channel 0: PERIOD=9, COMPARE=3
    bus_write(5, 9); bus_write(6, 3); bus_write(4, 3);
    bus_write(2, 1);
    cyc(); cyc();
    hi = 0;
    repeat (20) begin cyc(); hi += int'(pwm_out[0]); end
    chk("pwm_duty", 32'(hi), 32'd6);

    // PERIOD write while running
    bus_write(5, 4);
    addr = 5; cyc();
    chk("period_readback", readdata, 32'd4);
    addr = 7; repeat (12) cyc();
    bus_write(2, 32'h303);
    bus_write(0, 3);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = wa[$urandom_range(0, 15)];
        bus_write(a, rand_data(a));
      end else begin
        addr = 5'($urandom_range(0, 31));
        cyc();
      end
    end

    // Asynchronous reset in the middle of a count
    bus_write(4, 0); bus_write(2, 32'h300);
    bus_write(5, 20); bus_write(2, 1);
    addr = 7; repeat (3) cyc();
    #2 reset_n = 0;
    #1;
    chk("async_rst_readdata", readdata, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    chk("async_rst_pwm", {30'd0, pwm_out}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
    addr = 7; cyc();
    chk("async_rst_count", readdata, 32'd9999);
    addr = 0; cyc();
    chk("async_rst_status", readdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
